// File: rtl/store_drain_ctrl.sv
// +--------------------------------------------------------------------------+
// | store_drain_ctrl: drains the core store queue into BRAM ports, VG strobes |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef BRAM_PROG_RAM
`define BRAM_PROG_RAM 0
`endif
`ifndef BRAM_VECTOR
`define BRAM_VECTOR 1
`endif
`ifndef BRAM_PROG_ROM
`define BRAM_PROG_ROM 2
`endif

module store_drain_ctrl #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  qData,
  input  logic [15:0] qAddr,
  input  logic        qNotEmpty,
  output logic        canWrite,
  input  logic        halt,
  input  logic [2:0]  coreBusy,
  output logic [47:0] bramAddr,
  output logic [23:0] bramData,
  output logic [2:0]  bramWe,
  output logic        vggo,
  output logic        vgrst,
  output logic        stallReq,
  output logic [7:0]  errCount
);

  localparam logic [8:0] c_max_wait = 9'(MAX_WAIT);
  localparam logic [2:0] c_sel_ram  = 3'b001 << `BRAM_PROG_RAM;
  localparam logic [2:0] c_sel_vec  = 3'b001 << `BRAM_VECTOR;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    DEC_RAM = 3'd0,
    DEC_VEC = 3'd1,
    DEC_GO  = 3'd2,
    DEC_RST = 3'd3,
    DEC_ILL = 3'd4
  } dec_t;

  state_t      state_q, state_d;
  logic [15:0] h_addr_q, h_addr_d;
  logic [7:0]  h_data_q, h_data_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        stall_req_q, stall_req_d;
  logic [7:0]  err_count_q, err_count_d;

  dec_t        w_dec;
  logic [2:0]  w_sel;
  logic        w_port_busy;
  logic [8:0]  w_next_wait;

  always_comb begin
    w_dec = DEC_ILL;
    if (h_addr_q < 16'h0400)              w_dec = DEC_RAM;
    else if (h_addr_q[15:12] == 4'h2)     w_dec = DEC_VEC;
    else if (h_addr_q == 16'h1200)        w_dec = DEC_GO;
    else if (h_addr_q == 16'h1600)        w_dec = DEC_RST;
  end

  assign w_sel       = (w_dec == DEC_VEC) ? c_sel_vec : c_sel_ram;
  assign w_port_busy = |(coreBusy & w_sel);
  assign w_next_wait = {1'b0, wait_cnt_q} + 9'd1;

  always_comb begin
    state_d     = state_q;
    h_addr_d    = h_addr_q;
    h_data_d    = h_data_q;
    wait_cnt_d  = wait_cnt_q;
    stall_req_d = stall_req_q;
    err_count_d = err_count_q;
    canWrite    = 1'b0;
    bramWe      = '0;
    bramAddr    = '0;
    bramData    = '0;
    vggo        = 1'b0;
    vgrst       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Gated by rst so the pop strobe is low while reset is held
        canWrite = rst & ~halt;
        if (qNotEmpty && !halt) begin
          h_addr_d   = qAddr;
          h_data_d   = qData;
          wait_cnt_d = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        unique case (w_dec)
          DEC_GO: begin
            vggo    = 1'b1;
            state_d = ST_IDLE;
          end
          DEC_RST: begin
            vgrst   = 1'b1;
            state_d = ST_IDLE;
          end
          DEC_ILL: begin
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            state_d = ST_IDLE;
          end
          default: begin
            if (!w_port_busy) begin
              bramWe = w_sel;
              for (int i = 0; i < 3; i++) begin
                if (w_sel[i]) begin
                  bramAddr[16*i +: 16] = h_addr_q;
                  bramData[8*i +: 8]   = h_data_q;
                end
              end
              stall_req_d = 1'b0;
              state_d     = ST_IDLE;
            end else begin
              if (wait_cnt_q != 8'hFF) wait_cnt_d = w_next_wait[7:0];
              // Starved long enough: ask the core to freeze until we land
              if (w_next_wait >= c_max_wait) stall_req_d = 1'b1;
            end
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      h_addr_q    <= '0;
      h_data_q    <= '0;
      wait_cnt_q  <= '0;
      stall_req_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      h_addr_q    <= h_addr_d;
      h_data_q    <= h_data_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_req_q <= stall_req_d;
      err_count_q <= err_count_d;
    end
  end

  assign stallReq = stall_req_q;
  assign errCount = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_store_drain_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_store_drain_ctrl: self-checking bench with store-queue model          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_store_drain_ctrl;

  localparam int MAX_WAIT = 8;
  localparam int P_RAM    = 0;
  localparam int P_VEC    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  qData = '0;
  logic [15:0] qAddr = '0;
  logic        qNotEmpty = 1'b0;
  logic        canWrite;
  logic        halt = 1'b0;
  logic [2:0]  coreBusy = '0;
  logic [47:0] bramAddr;
  logic [23:0] bramData;
  logic [2:0]  bramWe;
  logic        vggo, vgrst, stallReq;
  logic [7:0]  errCount;

  always #5 clk = ~clk;

  store_drain_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .qData(qData), .qAddr(qAddr), .qNotEmpty(qNotEmpty),
    .canWrite(canWrite), .halt(halt), .coreBusy(coreBusy), .bramAddr(bramAddr),
    .bramData(bramData), .bramWe(bramWe), .vggo(vggo), .vgrst(vgrst),
    .stallReq(stallReq), .errCount(errCount)
  );

  typedef struct { logic [15:0] addr; logic [7:0] data; } ent_t;

  typedef struct {
    logic [15:0] addr; logic [7:0] data; logic [2:0] busy;
    logic [2:0] we; bit go; bit rs; int inc;
  } vec_t;

  ent_t sq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   landed = 0;

  // Reference model: at most one entry in flight, drained by address class
  bit   m_inflight;
  ent_t m_ent;
  int   m_wait;
  bit   m_stall;
  int   m_err;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 RAM, 1 VECTOR, 2 VGGO, 3 VGRST, 4 illegal
  function automatic int classify(input logic [15:0] a);
    if (a < 16'h0400) return 0;
    if (a >= 16'h2000 && a <= 16'h2FFF) return 1;
    if (a == 16'h1200) return 2;
    if (a == 16'h1600) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_wait = 0; m_stall = 0; m_err = 0;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    ent_t e;
    e.addr = a; e.data = d;
    sq.push_back(e);
  endtask

  task automatic apply(input logic [2:0] b, input logic h);
    @(negedge clk);
    coreBusy  = b;
    halt      = h;
    qNotEmpty = (sq.size() > 0);
    if (qNotEmpty) begin
      qAddr = sq[0].addr;
      qData = sq[0].data;
    end else begin
      qAddr = 16'($urandom);
      qData = 8'($urandom);
    end
    #1;
  endtask

  task automatic step();
    logic [2:0]  ewe;
    logic [47:0] ea;
    logic [23:0] ed;
    bit          eg, er, ecw;
    int          c, p;
    ewe = '0; ea = '0; ed = '0; eg = 0; er = 0; ecw = 0;
    c = classify(m_ent.addr);
    p = (c == 1) ? P_VEC : P_RAM;
    if (!m_inflight) ecw = !halt;
    else if (c == 2) eg = 1;
    else if (c == 3) er = 1;
    else if (c < 2 && !coreBusy[p]) begin
      ewe[p] = 1'b1;
      ea[16*p +: 16] = m_ent.addr;
      ed[8*p +: 8]   = m_ent.data;
    end
    chk("canWrite", canWrite, ecw);
    chk("bramWe", bramWe, ewe);
    chk("bramAddr", bramAddr, ea);
    chk("bramData", bramData, ed);
    chk("vggo", vggo, eg);
    chk("vgrst", vgrst, er);
    chk("stallReq", stallReq, m_stall);
    chk("errCount", errCount, m_err);
    if (bramWe != 0) landed++;
    @(posedge clk);
    if (!m_inflight) begin
      if (!halt && sq.size() > 0) begin
        m_ent = sq.pop_front();
        m_inflight = 1; m_wait = 0;
      end
    end else if (c >= 2) begin
      if (c == 4 && m_err < 255) m_err++;
      m_inflight = 0;
    end else if (!coreBusy[p]) begin
      m_inflight = 0; m_stall = 0;
    end else begin
      if (m_wait < 255) m_wait++;
      if (m_wait >= MAX_WAIT) m_stall = 1;
    end
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 16'($urandom_range(0, 16'h03FF));
      1:       return 16'(16'h2000 + $urandom_range(0, 16'h0FFF));
      2:       return 16'h1200;
      3:       return 16'h1600;
      4:       return 16'($urandom);
      default: return 16'(16'h5000 + $urandom_range(0, 16'h2FFF));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[12];
    logic [47:0] ea;
    logic [23:0] ed;
    int          tbl_err;
    int          hold;
    logic [2:0]  b;

    tbl[0]  = '{16'h0123, 8'hA5, 3'b000, 3'b001, 0, 0, 0};
    tbl[1]  = '{16'h03FF, 8'h11, 3'b110, 3'b001, 0, 0, 0};
    tbl[2]  = '{16'h0400, 8'h22, 3'b000, 3'b000, 0, 0, 1};
    tbl[3]  = '{16'h2000, 8'h33, 3'b001, 3'b010, 0, 0, 0};
    tbl[4]  = '{16'h2FFF, 8'h44, 3'b000, 3'b010, 0, 0, 0};
    tbl[5]  = '{16'h3000, 8'h55, 3'b000, 3'b000, 0, 0, 1};
    tbl[6]  = '{16'h1200, 8'h01, 3'b000, 3'b000, 1, 0, 0};
    tbl[7]  = '{16'h1600, 8'h02, 3'b000, 3'b000, 0, 1, 0};
    tbl[8]  = '{16'h5000, 8'h03, 3'b000, 3'b000, 0, 0, 1};
    tbl[9]  = '{16'h7FFF, 8'h04, 3'b000, 3'b000, 0, 0, 1};
    tbl[10] = '{16'h1201, 8'h05, 3'b000, 3'b000, 0, 0, 1};
    tbl[11] = '{16'h0000, 8'h66, 3'b100, 3'b001, 0, 0, 0};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_canWrite", canWrite, 0);
    chk("rst_bramWe", bramWe, 0);
    chk("rst_bramAddr", bramAddr, 0);
    chk("rst_bramData", bramData, 0);
    chk("rst_stallReq", stallReq, 0);
    chk("rst_errCount", errCount, 0);
    @(negedge clk);
    rst = 1'b1;

    // Table of single-entry transactions
    tbl_err = 0;
    for (int i = 0; i < 12; i++) begin
      push(tbl[i].addr, tbl[i].data);
      apply(3'b000, 1'b0);
      step();
      apply(tbl[i].busy, 1'b0);
      ea = '0; ed = '0;
      for (int p = 0; p < 3; p++) begin
        if (tbl[i].we[p]) begin
          ea[16*p +: 16] = tbl[i].addr;
          ed[8*p +: 8]   = tbl[i].data;
        end
      end
      chk("tbl_we", bramWe, tbl[i].we);
      chk("tbl_addr", bramAddr, ea);
      chk("tbl_data", bramData, ed);
      chk("tbl_vggo", vggo, tbl[i].go);
      chk("tbl_vgrst", vgrst, tbl[i].rs);
      chk("tbl_cw_issue", canWrite, 0);
      step();
      tbl_err += tbl[i].inc;
      apply(3'b000, 1'b0);
      chk("tbl_err", errCount, tbl_err);
      chk("tbl_cw_idle", canWrite, 1);
      step();
    end

    // Blocked VECTOR write with stall request
    push(16'h2400, 8'h5A);
    apply(3'b000, 1'b0);
    step();
    for (int k = 0; k < 10; k++) begin
      apply(3'b010, 1'b0);
      chk("blk_we", bramWe, 0);
      if (k == 7) chk("blk_stall_pre", stallReq, 0);
      if (k == 8) chk("blk_stall_set", stallReq, 1);
      step();
    end
    apply(3'b000, 1'b0);
    chk("blk_land_we", bramWe, 3'b010);
    chk("blk_land_addr", bramAddr[31:16], 16'h2400);
    chk("blk_land_stall", stallReq, 1);
    step();
    apply(3'b000, 1'b0);
    chk("blk_stall_clr", stallReq, 0);
    step();

    // Illegal write saturation
    for (int k = 0; k < 300; k++) begin
      push(16'h6000, 8'(k));
      apply(3'b000, 1'b0);
      step();
      apply(3'b000, 1'b0);
      step();
    end
    apply(3'b000, 1'b0);
    chk("ill_sat", errCount, 8'd255);
    step();

    // halt blocks pops but not the entry in flight
    for (int k = 0; k < 5; k++) push(16'(16'h0100 + k), 8'(8'hC0 + k));
    apply(3'b000, 1'b0);
    step();
    apply(3'b000, 1'b1);
    chk("halt_issue_we", bramWe, 3'b001);
    chk("halt_issue_addr", bramAddr[15:0], 16'h0100);
    step();
    for (int k = 0; k < 4; k++) begin
      apply(3'b000, 1'b1);
      chk("halt_cw", canWrite, 0);
      step();
    end
    landed = 0;
    for (int k = 0; k < 8; k++) begin
      apply(3'b000, 1'b0);
      step();
    end
    chk("halt_landed", landed, 4);

    // Asynchronous reset while a write is starved
    push(16'h0010, 8'h77);
    apply(3'b000, 1'b0);
    step();
    apply(3'b001, 1'b0);
    step();
    apply(3'b001, 1'b0);
    rst = 1'b0;
    #1;
    chk("arst_canWrite", canWrite, 0);
    chk("arst_bramWe", bramWe, 0);
    chk("arst_vggo", vggo, 0);
    chk("arst_stallReq", stallReq, 0);
    chk("arst_errCount", errCount, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    landed = 0;
    for (int k = 0; k < 4; k++) begin
      apply(3'b000, 1'b0);
      step();
    end
    chk("arst_no_write", landed, 0);

    // Randomized traffic against the model
    hold = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 2) == 0 && sq.size() < 6) push(rand_addr(), 8'($urandom));
      if (hold == 0 && $urandom_range(0, 149) == 0) hold = 12;
      if (hold > 0) begin
        b = 3'b111;
        hold--;
      end else begin
        for (int j = 0; j < 3; j++) b[j] = ($urandom_range(0, 3) == 0);
      end
      apply(b, ($urandom_range(0, 7) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
